// File: rtl/mul_operand_sequencer.sv
// Purpose: queues (A,B) operand pairs and feeds them one at a time to a start/ready
//          style multiplier, capturing each product into a single-entry result register.
// Latency: PUSH at edge n -> M_ST high in cycle n+2; RES_VALID rises on the edge after M_RD returns high.
// Backpressure: no new job issues while RES_VALID=1 and RES_ACK=0; pushes into a full queue are dropped (OVF).
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   PUSH, A, B        enqueue an operand pair (A -> IN0, B -> IN1)
//   FULL, LEVEL       queue full flag and occupancy
//   M_ST, M_IN0/1     start pulse and held operands towards the multiplier
//   M_RD, M_RES       multiplier ready (1 = idle/done) and its result
//   RES, RES_VALID    captured product and its valid flag
//   RES_ACK           consumer takes RES
//   OVF, ERR          sticky: dropped push / start never acknowledged
module mul_operand_sequencer #(
  parameter int BW    = 16,
  parameter int DEPTH = 4,
  parameter int TMO   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  logic [BW-1:0]            A,
  input  logic [BW-1:0]            B,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     M_ST,
  output logic [BW-1:0]            M_IN0,
  output logic [BW-1:0]            M_IN1,
  input  logic                     M_RD,
  input  logic [BW-1:0]            M_RES,
  output logic [BW-1:0]            RES,
  output logic                     RES_VALID,
  input  logic                     RES_ACK,
  output logic                     OVF,
  output logic                     ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  typedef struct packed {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } pair_t;

  // ---------------------------------------------------------------------------
  // Operand-pair queue
  // ---------------------------------------------------------------------------
  pair_t          mem [DEPTH];
  pair_t          wr_pair;
  pair_t          head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic           push_ok;
  logic           pop;
  logic           q_full;
  logic           q_empty;

  // FSM state
  logic [1:0]     state;
  logic [TW-1:0]  tmo_cnt;
  logic           tmo_hit;
  logic           capture;

  assign q_full  = (level == LW'(DEPTH));
  assign q_empty = (level == '0);

  // Acceptance looks only at the pre-edge level: a pop in the same cycle does
  // not make room for a push into a full queue.
  assign push_ok = PUSH && !q_full;

  // The head is popped on the IDLE->ISSUE edge. An ACK in the same cycle frees
  // the result register, so it may overlap with the next issue.
  assign pop = (state == S_IDLE) && !q_empty && (!RES_VALID || RES_ACK);

  assign wr_pair.a = A;
  assign wr_pair.b = B;
  assign head      = mem[rd_ptr];

  assign FULL  = q_full;
  assign LEVEL = level;

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge CLK) begin
    if (!RST && push_ok) begin
      mem[wr_ptr] <= wr_pair;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      OVF    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(push_ok) - LW'(pop);
      if (PUSH && q_full) begin
        OVF <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Job sequencing FSM
  // ---------------------------------------------------------------------------
  // tmo_cnt counts WAIT_BUSY cycles in which the multiplier still reports
  // ready; the TMO-th such cycle abandons the job.
  assign tmo_hit = (state == S_WAIT_BUSY) && M_RD && (tmo_cnt == TW'(TMO - 1));
  assign capture = (state == S_WAIT_DONE) && M_RD;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
      M_ST    <= 1'b0;
      M_IN0   <= '0;
      M_IN1   <= '0;
      ERR     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            M_IN0 <= head.a;
            M_IN1 <= head.b;
            M_ST  <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Start is a single-cycle pulse; operands stay put until IDLE.
          M_ST    <= 1'b0;
          tmo_cnt <= '0;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!M_RD) begin
            state <= S_WAIT_DONE;
          end else if (tmo_hit) begin
            ERR   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (M_RD) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Single-entry result register
  // ---------------------------------------------------------------------------
  // A capture on the same edge as an ACK wins: the old value is consumed and
  // the new product takes its place with RES_VALID still high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES       <= '0;
      RES_VALID <= 1'b0;
    end else if (capture) begin
      RES       <= M_RES;
      RES_VALID <= 1'b1;
    end else if (RES_ACK) begin
      RES_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
`timescale 1ns/1ps
module tb_mul_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [15:0] a;
  logic [15:0] b;
  logic        full;
  logic [2:0]  level;
  logic        m_st;
  logic [15:0] m_in0;
  logic [15:0] m_in1;
  logic        m_rd;
  logic [15:0] m_res;
  logic [15:0] res;
  logic        res_valid;
  logic        res_ack;
  logic        ovf;
  logic        err;

  logic        stub_stuck;
  int          stub_cnt;
  int          st_count;
  int          checks;
  int          failures;

  logic [15:0] ov_a   [5] = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10};
  logic [15:0] ov_b   [5] = '{16'd3, 16'd5, 16'd7, 16'd9, 16'd11};
  logic [15:0] ov_exp [4] = '{16'd6, 16'd20, 16'd42, 16'd72};

  always #5 clk = ~clk;

  mul_operand_sequencer #(.BW(16), .DEPTH(4), .TMO(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .PUSH      (push),
    .A         (a),
    .B         (b),
    .FULL      (full),
    .LEVEL     (level),
    .M_ST      (m_st),
    .M_IN0     (m_in0),
    .M_IN1     (m_in1),
    .M_RD      (m_rd),
    .M_RES     (m_res),
    .RES       (res),
    .RES_VALID (res_valid),
    .RES_ACK   (res_ack),
    .OVF       (ovf),
    .ERR       (err)
  );

  // Multiplier stub: busy for three cycles after a start, or ignores starts
  // entirely when stub_stuck is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_rd     <= 1'b1;
      stub_cnt <= 0;
      m_res    <= '0;
    end else if (m_rd) begin
      if (m_st && !stub_stuck) begin
        m_rd     <= 1'b0;
        stub_cnt <= 3;
        m_res    <= 16'(m_in0 * m_in1);
      end
    end else if (stub_cnt <= 1) begin
      m_rd <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  always_ff @(posedge clk) begin
    if (m_st) st_count <= st_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] x, input logic [15:0] y);
    a = x; b = y; push = 1'b1;
    step();
    push = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (res_valid === 1'b1) ok = 1'b1;
  endtask

  task automatic ack_result();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] x, input logic [15:0] y,
                         output bit ok, output logic [15:0] r);
    push_pair(x, y);
    wait_valid(30, ok);
    r = res;
    ack_result();
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b1; a = 16'd1; b = 16'd1; res_ack = 1'b1;
    step();
    step();
    checks++; if (level !== 3'd0)     begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (full !== 1'b0)      begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (m_st !== 1'b0)      begin failures++; $display("FAIL reset_m_st got=%b exp=0", m_st); end
    checks++; if ({m_in0, m_in1} !== 32'd0) begin failures++; $display("FAIL reset_m_in got=%h exp=0", {m_in0, m_in1}); end
    checks++; if (res !== 16'd0 || res_valid !== 1'b0) begin failures++; $display("FAIL reset_res got=%0d/%b exp=0/0", res, res_valid); end
    checks++; if (ovf !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags got ovf=%b err=%b exp=0/0", ovf, err); end
    rst = 1'b0; push = 1'b0; res_ack = 1'b0;
    step();
    checks++; if (level !== 3'd0 || m_st !== 1'b0) begin failures++; $display("FAIL reset_push_ignored got level=%0d m_st=%b exp=0/0", level, m_st); end
  endtask

  task automatic test_basic();
    int st0;
    bit ok;
    st0 = st_count;
    push_pair(16'd3, 16'd5);
    checks++; if (level !== 3'd1 || m_st !== 1'b0) begin failures++; $display("FAIL basic_queued got level=%0d m_st=%b exp=1/0", level, m_st); end
    step();
    checks++; if (m_st !== 1'b1) begin failures++; $display("FAIL basic_start got=%b exp=1", m_st); end
    checks++; if (m_in0 !== 16'd3 || m_in1 !== 16'd5) begin failures++; $display("FAIL basic_operands got=%0d,%0d exp=3,5", m_in0, m_in1); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL basic_popped got=%0d exp=0", level); end
    step();
    checks++; if (m_st !== 1'b0) begin failures++; $display("FAIL basic_start_pulse got=%b exp=0", m_st); end
    wait_valid(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_valid_timeout got=0 exp=1"); end
    checks++; if (res !== 16'd15) begin failures++; $display("FAIL basic_res got=%0d exp=15", res); end
    repeat (3) step();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_hold_valid got=%b exp=1", res_valid); end
    checks++; if (st_count - st0 !== 1) begin failures++; $display("FAIL basic_start_count got=%0d exp=1", st_count - st0); end
    ack_result();
    checks++; if (res_valid !== 1'b0 || res !== 16'd15) begin failures++; $display("FAIL basic_ack got=%b/%0d exp=0/15", res_valid, res); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] r;
    run_job(16'd300, 16'd300, ok, r);
    checks++; if (!ok || r !== 16'd24464) begin failures++; $display("FAIL wrap_300x300 got=%0d ok=%b exp=24464", r, ok); end
    run_job(16'd7, 16'd0, ok, r);
    checks++; if (!ok || r !== 16'd0) begin failures++; $display("FAIL zero_7x0 got=%0d ok=%b exp=0", r, ok); end
  endtask

  task automatic test_overflow();
    int st0;
    bit ok;
    st0 = st_count;
    // Leave one result unconsumed so nothing is popped while filling.
    push_pair(16'd1, 16'd1);
    wait_valid(30, ok);
    checks++; if (!ok || res !== 16'd1) begin failures++; $display("FAIL ovf_setup got=%0d ok=%b exp=1", res, ok); end
    for (int i = 0; i < 4; i++) push_pair(ov_a[i], ov_b[i]);
    checks++; if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin failures++; $display("FAIL ovf_filled got level=%0d full=%b ovf=%b exp=4/1/0", level, full, ovf); end
    push_pair(ov_a[4], ov_b[4]);
    checks++; if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_dropped got level=%0d full=%b ovf=%b exp=4/1/1", level, full, ovf); end
    ack_result();
    for (int i = 0; i < 4; i++) begin
      logic [15:0] r;
      wait_valid(30, ok);
      r = res;
      ack_result();
      checks++; if (!ok || r !== ov_exp[i]) begin failures++; $display("FAIL ovf_result%0d got=%0d ok=%b exp=%0d", i, r, ok, ov_exp[i]); end
    end
    repeat (10) step();
    checks++; if (st_count - st0 !== 5 || level !== 3'd0 || full !== 1'b0) begin failures++; $display("FAIL ovf_no_fifth got starts=%0d level=%0d exp=5/0", st_count - st0, level); end
  endtask

  task automatic test_backpressure();
    int st0;
    bit ok;
    st0 = st_count;
    push_pair(16'd2, 16'd2);
    push_pair(16'd3, 16'd3);
    wait_valid(30, ok);
    checks++; if (!ok || res !== 16'd4) begin failures++; $display("FAIL bp_first got=%0d ok=%b exp=4", res, ok); end
    repeat (8) step();
    checks++; if (st_count - st0 !== 1 || level !== 3'd1 || res_valid !== 1'b1) begin failures++; $display("FAIL bp_withheld got starts=%0d level=%0d exp=1/1", st_count - st0, level); end
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    checks++; if (m_st !== 1'b1 || m_in0 !== 16'd3) begin failures++; $display("FAIL bp_issue_on_ack got m_st=%b in0=%0d exp=1/3", m_st, m_in0); end
    wait_valid(30, ok);
    checks++; if (!ok || res !== 16'd9) begin failures++; $display("FAIL bp_second got=%0d ok=%b exp=9", res, ok); end
    ack_result();
  endtask

  task automatic test_timeout();
    bit ok;
    logic [15:0] r;
    stub_stuck = 1'b1;
    push_pair(16'd5, 16'd5);
    step();
    checks++; if (m_st !== 1'b1) begin failures++; $display("FAIL tmo_start got=%b exp=1", m_st); end
    step();
    repeat (3) step();
    checks++; if (err !== 1'b0 || m_in0 !== 16'd5) begin failures++; $display("FAIL tmo_early got err=%b in0=%0d exp=0/5", err, m_in0); end
    step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", err); end
    checks++; if (res_valid !== 1'b0 || res !== 16'd9) begin failures++; $display("FAIL tmo_res got=%b/%0d exp=0/9", res_valid, res); end
    stub_stuck = 1'b0;
    run_job(16'd6, 16'd7, ok, r);
    checks++; if (!ok || r !== 16'd42 || err !== 1'b1) begin failures++; $display("FAIL tmo_next_job got=%0d ok=%b err=%b exp=42/1/1", r, ok, err); end
  endtask

  task automatic test_reset_midjob();
    logic seen;
    push_pair(16'd9, 16'd9);
    step();
    step();
    step();
    checks++; if (m_in0 !== 16'd9 || res_valid !== 1'b0 || m_rd !== 1'b0) begin failures++; $display("FAIL mid_setup got in0=%0d valid=%b rd=%b exp=9/0/0", m_in0, res_valid, m_rd); end
    rst = 1'b1; push = 1'b1; a = 16'd4; b = 16'd4; res_ack = 1'b1;
    step();
    rst = 1'b0; push = 1'b0; res_ack = 1'b0;
    checks++; if (level !== 3'd0 || full !== 1'b0 || m_st !== 1'b0) begin failures++; $display("FAIL mid_reset_q got level=%0d full=%b m_st=%b exp=0/0/0", level, full, m_st); end
    checks++; if ({m_in0, m_in1, res} !== 48'd0 || res_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_data got=%h valid=%b exp=0/0", {m_in0, m_in1, res}, res_valid); end
    checks++; if (ovf !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_reset_flags got ovf=%b err=%b exp=0/0", ovf, err); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (res_valid !== 1'b0 || m_st !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL mid_no_capture got seen=%b level=%0d exp=0/0", seen, level); end
  endtask

  initial begin
    checks = 0; failures = 0; st_count = 0;
    rst = 1'b1; push = 1'b0; a = '0; b = '0; res_ack = 1'b0; stub_stuck = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_backpressure();
    test_timeout();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_operand_sequencer.md
MUL_OPERAND_SEQUENCER -- requirements
Module: mul_operand_sequencer

Interface
REQ-001 Parameter BW, 16, width of operands and results.
REQ-002 Parameter DEPTH, 4, operand-pair queue entries (power of two, 2..16).
REQ-003 Parameter TMO, 4, cycles allowed for M_RD to drop after a start.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 PUSH  input  1  enqueue request for pair (A,B).
REQ-007 A  input  BW  multiplicand, routed to multiplier IN0.
REQ-008 B  input  BW  multiplier count, routed to multiplier IN1.
REQ-009 FULL  output  1  queue holds DEPTH entries.
REQ-010 LEVEL  output  clog2(DEPTH)+1  current queue occupancy.
REQ-011 M_ST  output  1  start to downstream multiplier ST.
REQ-012 M_IN0, M_IN1  output  BW each  operands to multiplier IN0/IN1.
REQ-013 M_RD  input  1  multiplier RD (1 = idle/done, 0 = busy).
REQ-014 M_RES  input  BW  multiplier RES.
REQ-015 RES  output  BW  captured product.
REQ-016 RES_VALID  output  1  RES holds an unconsumed product.
REQ-017 RES_ACK  input  1  consumer takes RES this cycle.
REQ-018 OVF  output  1  sticky: push dropped because queue full.
REQ-019 ERR  output  1  sticky: start not acknowledged within TMO cycles.

Function
REQ-020 Queue SHALL be FIFO; push accepted iff LEVEL<DEPTH before the edge, regardless of a same-cycle pop.
REQ-021 Push while full SHALL be discarded and SHALL set OVF; queue contents unchanged.
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE -> ISSUE when queue non-empty and (RES_VALID=0 or RES_ACK=1); on that edge head entry popped, M_IN0<=A, M_IN1<=B, M_ST<=1.
REQ-024 M_ST SHALL be high for exactly one cycle (ISSUE only); ISSUE -> WAIT_BUSY unconditionally.
REQ-025 M_IN0/M_IN1 SHALL stay constant from ISSUE until return to IDLE.
REQ-026 WAIT_BUSY -> WAIT_DONE on first cycle M_RD=0; if M_RD stays 1 for TMO cycles after ISSUE, set ERR, discard job, go IDLE, RES unchanged.
REQ-027 WAIT_DONE -> IDLE on first cycle M_RD=1; on that edge RES<=M_RES unmodified (mod 2^BW as produced), RES_VALID<=1.
REQ-028 RES_VALID SHALL clear on RES_ACK=1; a same-cycle capture (REQ-027) SHALL win, leaving RES_VALID=1 with the new value.
REQ-029 RES_ACK with RES_VALID=0 SHALL be ignored.
REQ-030 No new job SHALL issue while RES_VALID=1 and RES_ACK=0 (single-entry output backpressure).
REQ-031 Minimum job latency: PUSH edge n -> M_ST high cycle n+2 (IDLE sees entry at n+1) -> RES_VALID at edge after M_RD returns to 1.
REQ-032 Jobs SHALL complete in push order; at most one job outstanding at the multiplier.

Reset
REQ-033 While RST=1 at an edge: state IDLE, queue flushed, LEVEL=0, FULL=0, M_ST=0, M_IN0=M_IN1=0, RES=0, RES_VALID=0, OVF=0, ERR=0.
REQ-034 Reset mid-job SHALL abandon the job with no capture; multiplier shares RST and is reset in the same cycle.
REQ-035 PUSH and RES_ACK SHALL be ignored in any cycle RST=1.

Verification
REQ-036 Push (3,5), multiplier attached -> one M_ST pulse, M_IN0=3, M_IN1=5, RES=15, RES_VALID=1 until ACK.
REQ-037 Push (300,300) -> RES=24464 (90000 mod 65536); push (7,0) -> RES=0.
REQ-038 Five pushes back-to-back, no pops -> LEVEL=4, FULL=1, OVF=1, fifth pair never issued; first four results in order.
REQ-039 Two jobs queued, RES_ACK held 0 -> second M_ST withheld until ACK; then issued, second RES captured.
REQ-040 Multiplier stub holding M_RD=1 -> after 4 cycles ERR=1, state IDLE, RES_VALID=0, next job issues.
REQ-041 RST asserted during WAIT_DONE -> all outputs at REQ-033 values next cycle; no RES_VALID afterwards.
